// File: rtl/key_debounce.sv
// Push-button debouncer: two-flop synchroniser, then a filter FSM that accepts a press
// or release only after CNT_MAX+1 consecutive samples at the new level. It emits a
// one-cycle flag per press, a one-cycle release_flag per release, and a debounced level.
module key_debounce #(
    parameter int unsigned CNT_MAX = 1_000_000,
    parameter int unsigned CNT_W   = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic flag,
    output logic release_flag,
    output logic key_state
);

    typedef enum logic [1:0] {
        StIdle,
        StPressFilter,
        StDown,
        StReleaseFilter
    } state_e;

    // Last count value of a filter window; the window completes when cnt reaches it.
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(CNT_MAX - 1);

    logic             sync1_q;
    logic             key_sync_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flag_q, flag_d;
    logic             release_q, release_d;
    logic             key_state_q, key_state_d;

    // Synchronise the asynchronous key; idle level is high (released).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b1;
            key_sync_q <= 1'b1;
        end else begin
            sync1_q    <= key_in;
            key_sync_q <= sync1_q;
        end
    end

    // FSM, filter counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            flag_q      <= 1'b0;
            release_q   <= 1'b0;
            key_state_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flag_q      <= flag_d;
            release_q   <= release_d;
            key_state_q <= key_state_d;
        end
    end

    // Next-state logic; the bounce check is evaluated before the count check.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        flag_d      = 1'b0;
        release_d   = 1'b0;
        key_state_d = key_state_q;
        unique case (state_q)
            StIdle: begin
                if (!key_sync_q) begin
                    state_d = StPressFilter;
                    cnt_d   = '0;
                end
            end
            StPressFilter: begin
                if (key_sync_q) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d     = StDown;
                    cnt_d       = '0;
                    flag_d      = 1'b1;
                    key_state_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDown: begin
                if (key_sync_q) begin
                    state_d = StReleaseFilter;
                    cnt_d   = '0;
                end
            end
            StReleaseFilter: begin
                if (!key_sync_q) begin
                    state_d = StDown;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d     = StIdle;
                    cnt_d       = '0;
                    release_d   = 1'b1;
                    key_state_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign flag         = flag_q;
    assign release_flag = release_q;
    assign key_state    = key_state_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with CNT_MAX=8: a per-cycle vector table covering
// clean press/release, bouncy press, release glitch and release, plus hand-written
// sequences for reset behaviour and a long hold.
module tb_key_debounce;

    localparam int unsigned CntMax = 8;
    localparam int unsigned CntW   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_in = 1'b1;
    logic flag;
    logic release_flag;
    logic key_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int   id;
        logic key;
        logic e_flag;
        logic e_rel;
        logic e_state;
    } vec_t;

    vec_t vecs[$];

    key_debounce #(
        .CNT_MAX(CntMax),
        .CNT_W  (CntW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .flag        (flag),
        .release_flag(release_flag),
        .key_state   (key_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input int idx, input logic ef, input logic er,
                           input logic es);
        chk({name, ".flag"}, idx, flag, ef);
        chk({name, ".release_flag"}, idx, release_flag, er);
        chk({name, ".key_state"}, idx, key_state, es);
    endtask

    // Drive key level, advance one edge, sample just after it.
    task automatic step(input logic k);
        key_in = k;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic k, input logic f, input logic r, input logic s);
        vec_t v;
        v.id = id; v.key = k; v.e_flag = f; v.e_rel = r; v.e_state = s;
        vecs.push_back(v);
    endtask

    int nflag;

    initial begin
        // Vector table. Index i of each group = edge E_i counted from that group's start.
        // Clean press: flag at E10, key_state low from E10.
        for (int i = 0; i < 30; i++) push(1, 1'b0, i == 10, 1'b0, !(i >= 10));
        // Clean release: release_flag at E10, key_state high from E10.
        for (int i = 0; i < 15; i++) push(2, 1'b1, 1'b0, i == 10, (i >= 10));
        // Bouncy press: 0x5 1x3 0x2 1x1 then 0x20; last falling sample is index 11 -> flag E21.
        for (int i = 0; i < 31; i++) begin
            logic k;
            k = !((i < 5) || (i >= 8 && i < 10) || (i >= 11));
            push(3, k, i == 21, 1'b0, !(i >= 21));
        end
        // Release glitch from DOWN: 1x4 then 0x20, nothing changes.
        for (int i = 0; i < 24; i++) push(4, (i < 4), 1'b0, 1'b0, 1'b0);
        // Real release afterwards proves the FSM was still in DOWN.
        for (int i = 0; i < 15; i++) push(5, 1'b1, 1'b0, i == 10, (i >= 10));

        // Reset held with key toggling.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(i[0]);
            chk_all("reset_hold", i, 1'b0, 1'b0, 1'b1);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'b1);
            chk_all("reset_after", i, 1'b0, 1'b0, 1'b1);
        end
        for (int i = 0; i < 4; i++) step(1'b1);

        // Apply vector table.
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].key);
            chk_all($sformatf("vec%0d", vecs[i].id), i, vecs[i].e_flag, vecs[i].e_rel,
                    vecs[i].e_state);
        end

        // Long hold: exactly one flag at E10 over 200 cycles.
        nflag = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b0);
            if (flag) nflag++;
            if (i == 10) chk("long_hold.flag_at_e10", i, flag, 1'b1);
        end
        checks++;
        if (nflag != 1) begin
            errors++;
            $display("FAIL long_hold.count got %0d expected 1", nflag);
        end
        chk("long_hold.key_state", 200, key_state, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b1);
        chk("long_hold.released", 0, key_state, 1'b1);

        // Reset mid-filter: PRESS_FILTER entered at E2, cnt=5 after E7.
        for (int i = 0; i < 8; i++) step(1'b0);
        rst_n = 1'b0;
        #1;
        chk_all("rst_mid.immediate", 0, 1'b0, 1'b0, 1'b1);
        nflag = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            if (flag) nflag++;
            chk_all("rst_mid.held", i, 1'b0, 1'b0, 1'b1);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step(1'b0);
            if (flag) nflag++;
            chk_all("rst_mid.refilter", i, i == 10, 1'b0, !(i >= 10));
        end
        checks++;
        if (nflag != 1) begin
            errors++;
            $display("FAIL rst_mid.count got %0d expected 1", nflag);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
